// File: rtl/apb_pkg.sv
// Shared types and constants for the APB4 slave family.
package apb_pkg;
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} apb_slv_state_e;

  localparam int WAIT_CNT_W = 4;

  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction
endpackage

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master (bridge/bench) and the memory slave.
interface apb4_mem_slave_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_W = apb_pkg::strb_w(DATA_WIDTH);

  logic                  psel;
  logic                  pen;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, pen, pwrite, paddr, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, pen, pwrite, paddr, pwdata, pstrb,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb4_byte_mem.sv
// Word storage with per-byte write enables and a registered, resettable read port.
module apb4_byte_mem
  import apb_pkg::*;
#(
  parameter  int DEPTH      = 256,
  parameter  int DATA_WIDTH = 32,
  parameter  int AW         = 8,
  localparam int STRB_W     = strb_w(DATA_WIDTH)
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic [STRB_W-1:0]     we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  input  logic                  rd_ok,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Array contents are intentionally left unreset.
  always_ff @(posedge pclk) begin
    for (int i = 0; i < STRB_W; i++)
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst)      rdata <= '0;
    else if (rd_en) rdata <= rd_ok ? mem[raddr] : '0;
  end
endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave: byte strobes, fixed wait states, PSLVERR on out-of-range words.
module apb4_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic             pclk,
  input  logic             prst,
  apb4_mem_slave_if.slave  bus
);
  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WS_L    = WAIT_CNT_W'(WAIT_STATES);

  if (DATA_WIDTH < 8 || DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $fatal(1, "apb4_mem_slave: DATA_WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 1 || DEPTH > 2**ADDR_WIDTH) begin : g_bad_depth
    $fatal(1, "apb4_mem_slave: DEPTH must be in 1..2**ADDR_WIDTH");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 2**WAIT_CNT_W - 1) begin : g_bad_ws
    $fatal(1, "apb4_mem_slave: WAIT_STATES must be in 0..15");
  end

  apb_slv_state_e        state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic                  setup, complete, in_range;
  logic [STRB_W-1:0]     we;
  logic [DATA_WIDTH-1:0] rdata;

  assign in_range = {1'b0, bus.paddr} < DEPTH_L;

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      err_q   <= err_d;
    end
  end

  // Address, direction and error are frozen at setup; later bus changes are ignored.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    write_d  = write_q;
    err_d    = err_q;
    setup    = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.psel && !bus.pen) begin
          setup   = 1'b1;
          state_d = ACCESS;
          cnt_d   = WS_L;
          addr_d  = bus.paddr[AW-1:0];
          write_d = bus.pwrite;
          err_d   = !in_range;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          state_d = IDLE;
        end else if (bus.pen) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
          end else begin
            complete = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign we          = (complete && write_q && !err_q) ? bus.pstrb : '0;
  assign bus.pready  = complete;
  assign bus.pslverr = complete && err_q;
  assign bus.prdata  = (complete && !write_q && !err_q) ? rdata : '0;

  apb4_byte_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_mem (
    .pclk  (pclk),
    .prst  (prst),
    .we    (we),
    .waddr (addr_q),
    .wdata (bus.pwdata),
    .rd_en (setup),
    .rd_ok (in_range),
    .raddr (bus.paddr[AW-1:0]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_apb4_mem_slave.sv
// Directed bench: four slave configurations share one driven bus, one selected at a time.
module tb_apb4_mem_slave;
  logic        pclk = 1'b0;
  logic        prst = 1'b0;
  logic        psel_d = 1'b0, pen_d = 1'b0, pwrite_d = 1'b0;
  logic [7:0]  paddr_d = '0;
  logic [31:0] pwdata_d = '0;
  logic [3:0]  pstrb_d = '0;
  int          tgt = 0;
  int          cyc = 0;
  int          setup_cyc, done_cyc, prev_done;
  int          n_cmp = 0, n_bad = 0;

  logic        pready_m, pslverr_m;
  logic [31:0] prdata_m;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cyc <= cyc + 1;

  apb4_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_a ();
  apb4_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_b ();
  apb4_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_c ();
  apb4_mem_slave_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) if_d ();

  assign if_a.psel = psel_d && (tgt == 0);
  assign if_b.psel = psel_d && (tgt == 1);
  assign if_c.psel = psel_d && (tgt == 2);
  assign if_d.psel = psel_d && (tgt == 3);
  assign {if_a.pen, if_b.pen, if_c.pen, if_d.pen} = {4{pen_d}};
  assign {if_a.pwrite, if_b.pwrite, if_c.pwrite, if_d.pwrite} = {4{pwrite_d}};
  assign {if_a.paddr, if_b.paddr, if_c.paddr, if_d.paddr} = {4{paddr_d}};
  assign {if_a.pwdata, if_b.pwdata, if_c.pwdata, if_d.pwdata} = {4{pwdata_d}};
  assign {if_a.pstrb, if_b.pstrb, if_c.pstrb, if_d.pstrb} = {4{pstrb_d}};

  apb4_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0))
    dut_a (.pclk(pclk), .prst(prst), .bus(if_a));
  apb4_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(64),  .WAIT_STATES(3))
    dut_b (.pclk(pclk), .prst(prst), .bus(if_b));
  apb4_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(2))
    dut_c (.pclk(pclk), .prst(prst), .bus(if_c));
  apb4_mem_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(1))
    dut_d (.pclk(pclk), .prst(prst), .bus(if_d));

  always_comb begin
    pready_m = if_a.pready; pslverr_m = if_a.pslverr; prdata_m = if_a.prdata;
    case (tgt)
      1: begin pready_m = if_b.pready; pslverr_m = if_b.pslverr; prdata_m = if_b.prdata; end
      2: begin pready_m = if_c.pready; pslverr_m = if_c.pslverr; prdata_m = if_c.prdata; end
      3: begin pready_m = if_d.pready; pslverr_m = if_d.pslverr; prdata_m = if_d.prdata; end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One transfer. Setup drives junk data/strobe; access flips address and direction,
  // so the slave must use captured addr/dir and completion-time data/strobe.
  task automatic xfer(input string tag, input int t, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int exp_lat,
                      input bit exp_err, input logic [31:0] exp_rd);
    int  lat;
    bit  done;
    @(posedge pclk); #1;
    tgt = t;
    psel_d = 1'b1; pen_d = 1'b0; pwrite_d = wr; paddr_d = a; pwdata_d = ~d; pstrb_d = ~s;
    @(negedge pclk);
    setup_cyc = cyc;
    chk({tag, "/setup_rdy"}, 32'(pready_m), 32'd0);
    @(posedge pclk); #1;
    pen_d = 1'b1; pwrite_d = ~wr; paddr_d = ~a; pwdata_d = d; pstrb_d = s;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge pclk);
      lat++;
      if (pready_m) begin
        done = 1'b1;
        done_cyc = cyc;
        chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/slverr"}, 32'(pslverr_m), 32'(exp_err));
        chk({tag, "/rdata"}, prdata_m, exp_rd);
      end else begin
        chk({tag, "/wait_rdata"}, prdata_m, 32'd0);
        chk({tag, "/wait_slverr"}, 32'(pslverr_m), 32'd0);
        @(posedge pclk); #1;
      end
    end
    if (!done) chk({tag, "/timeout"}, 32'd0, 32'd1);
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel_d = 1'b0; pen_d = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge pclk);
    for (int t = 0; t < 4; t++) begin
      tgt = t; #1;
      chk("rst/pready", 32'(pready_m), 32'd0);
      chk("rst/pslverr", 32'(pslverr_m), 32'd0);
      chk("rst/prdata", prdata_m, 32'd0);
    end
    @(negedge pclk); prst = 1'b1;

    // Zero wait states: full write/read, partial strobe, empty strobe.
    xfer("t1_wr", 0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0, 32'd0);
    xfer("t1_rd", 0, 1'b0, 8'h10, 32'h0, 4'h0, 1, 1'b0, 32'hDEADBEEF);
    xfer("t2_wr", 0, 1'b1, 8'h10, 32'h11223344, 4'b0101, 1, 1'b0, 32'd0);
    xfer("t2_rd", 0, 1'b0, 8'h10, 32'h0, 4'h0, 1, 1'b0, 32'hDE22BE44);
    xfer("nostrb_wr", 0, 1'b1, 8'h10, 32'h99999999, 4'h0, 1, 1'b0, 32'd0);
    xfer("nostrb_rd", 0, 1'b0, 8'h10, 32'h0, 4'h0, 1, 1'b0, 32'hDE22BE44);
    idle();

    // Access without a setup phase must be ignored.
    xfer("pv_pre", 0, 1'b1, 8'h30, 32'h0000C0DE, 4'hF, 1, 1'b0, 32'd0);
    idle();
    @(posedge pclk); #1;
    psel_d = 1'b1; pen_d = 1'b1; pwrite_d = 1'b1; paddr_d = 8'h30;
    pwdata_d = 32'hBAD0BAD0; pstrb_d = 4'hF;
    repeat (2) begin
      @(negedge pclk);
      chk("pv/pready", 32'(pready_m), 32'd0);
    end
    idle();
    xfer("pv_rd", 0, 1'b0, 8'h30, 32'h0, 4'h0, 1, 1'b0, 32'h0000C0DE);
    idle();

    // Three wait states, 64-word depth with out-of-range words.
    xfer("t3_wr", 1, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 4, 1'b0, 32'd0);
    xfer("t3_rd", 1, 1'b0, 8'h10, 32'h0, 4'h0, 4, 1'b0, 32'hDEADBEEF);
    xfer("t4_wr", 1, 1'b1, 8'h50, 32'hFFFFFFFF, 4'hF, 4, 1'b1, 32'd0);
    xfer("t4_rd", 1, 1'b0, 8'h50, 32'h0, 4'h0, 4, 1'b1, 32'd0);
    xfer("t4_alias", 1, 1'b0, 8'h10, 32'h0, 4'h0, 4, 1'b0, 32'hDEADBEEF);
    xfer("edge_rd", 1, 1'b0, 8'h40, 32'h0, 4'h0, 4, 1'b1, 32'd0);
    idle();

    // Master abort during wait states leaves memory untouched.
    xfer("t5_pre", 2, 1'b1, 8'h20, 32'h12345678, 4'hF, 3, 1'b0, 32'd0);
    idle();
    @(posedge pclk); #1;
    tgt = 2;
    psel_d = 1'b1; pen_d = 1'b0; pwrite_d = 1'b1; paddr_d = 8'h20;
    pwdata_d = 32'hA5A5A5A5; pstrb_d = 4'hF;
    @(posedge pclk); #1; pen_d = 1'b1;
    @(negedge pclk); chk("t5/wait1", 32'(pready_m), 32'd0);
    @(posedge pclk); #1; psel_d = 1'b0; pen_d = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      chk("t5/abort_rdy", 32'(pready_m), 32'd0);
    end
    xfer("t5_rd", 2, 1'b0, 8'h20, 32'h0, 4'h0, 3, 1'b0, 32'h12345678);
    idle();

    // Reset in the completing cycle of a write; then back-to-back write/read.
    xfer("t6_pre", 3, 1'b1, 8'h05, 32'h01020304, 4'hF, 2, 1'b0, 32'd0);
    idle();
    @(posedge pclk); #1;
    tgt = 3;
    psel_d = 1'b1; pen_d = 1'b0; pwrite_d = 1'b1; paddr_d = 8'h05;
    pwdata_d = 32'hCAFEF00D; pstrb_d = 4'hF;
    @(posedge pclk); #1; pen_d = 1'b1;
    @(negedge pclk); chk("t6/wait1", 32'(pready_m), 32'd0);
    @(posedge pclk); #2;
    chk("t6/pre_rst_rdy", 32'(pready_m), 32'd1);
    prst = 1'b0; #1;
    chk("t6/rst_rdy", 32'(pready_m), 32'd0);
    chk("t6/rst_slverr", 32'(pslverr_m), 32'd0);
    chk("t6/rst_rdata", prdata_m, 32'd0);
    @(posedge pclk); #1; psel_d = 1'b0; pen_d = 1'b0;
    @(negedge pclk); prst = 1'b1;
    xfer("t6_rd_old", 3, 1'b0, 8'h05, 32'h0, 4'h0, 2, 1'b0, 32'h01020304);
    idle();
    xfer("t6_wr", 3, 1'b1, 8'h05, 32'h55AA55AA, 4'hF, 2, 1'b0, 32'd0);
    prev_done = done_cyc;
    xfer("t6_rd", 3, 1'b0, 8'h05, 32'h0, 4'h0, 2, 1'b0, 32'h55AA55AA);
    chk("t6/b2b_gap", 32'(setup_cyc - prev_done), 32'd1);
    idle();

    repeat (2) @(posedge pclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/apb4_mem_slave.md
Name: apb4_mem_slave

Overview:
Parametrised APB4 memory-mapped slave, the successor to the team's fixed-width APB slave. It adds byte strobes, configurable wait states, and PSLVERR for out-of-range addresses. It sits on the peripheral bus behind the APB bridge as scratch/config storage and is the DUT target for the APB UVM environment.

Parameters:
ADDR_WIDTH, 8, width of paddr; paddr is a word index, not a byte address
DATA_WIDTH, 32, data bus width; must be a multiple of 8 (elaboration-time check, fatal otherwise)
DEPTH, 256, number of words implemented; must be <= 2**ADDR_WIDTH
WAIT_STATES, 0, number of pready-low access cycles before completion (0..15)

Ports:
pclk  in  1  bus clock, all logic on rising edge
prst  in  1  asynchronous active-low reset
psel  in  1  slave select
pen  in  1  enable (access phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_WIDTH  word address
pwdata  in  DATA_WIDTH  write data
pstrb  in  DATA_WIDTH/8  byte write strobes
prdata  out  DATA_WIDTH  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error, valid only with pready

Behaviour:
- Reset (prst=0, asynchronous): state=IDLE, wait counter=0, internal read register=0. prdata=0, pready=0, pslverr=0. Memory contents are not reset.
- State IDLE:
  - psel=1 and pen=0 (setup phase): capture paddr and pwrite, load wait counter with WAIT_STATES, register mem[paddr] into the read register (0 if out of range), then go to ACCESS.
  - psel=1 and pen=1 with no preceding setup: protocol violation. Stay in IDLE, pready stays 0, no memory effect.
- State ACCESS:
  - psel=1, pen=1, counter>0: pready=0, counter decrements each cycle.
  - psel=1, pen=1, counter=0: pready=1 combinationally. This is the completing cycle. On its rising edge go to IDLE.
  - psel=0 (master abort): return to IDLE, no write, pready=0.
- Latency: pready rises in access cycle WAIT_STATES+1. With WAIT_STATES=0 the transfer takes exactly 2 cycles (setup + access).
- Error: captured address >= DEPTH gives pslverr=1 during the completing cycle. Writes are discarded; prdata=0.
- Write commit: at the completing edge with pwrite=1 and no error, for each byte i with pstrb[i]=1, mem[addr][8i+7:8i] <= pwdata byte i. pwdata and pstrb are sampled at the completing edge, not at setup. pstrb=0 is a legal no-op and completes with pslverr=0.
- Read: prdata = read register only when pready=1, the captured direction is read, and there is no error. Otherwise prdata=0.
- pslverr=0 whenever pready=0.
- Back-to-back: a setup phase in the cycle right after completion is accepted from IDLE with no bubble.
- Direction or address changes between setup and access phase are ignored; the captured values are used.
- Reset asserted mid-access: immediate return to IDLE with outputs low. A pending write never commits.

Decomposition:
- Shared package apb_pkg:
  - state enum apb_slv_state_e {IDLE, ACCESS}
  - constant STRB_W = DATA_WIDTH/8 (as a function)
  - WAIT_CNT_W = 4
- Sub-module apb4_byte_mem: DEPTH x DATA_WIDTH storage with per-byte write enable and registered read port.
- FSM, wait counter, error decode and output muxing live in apb4_mem_slave.

Test Plan:
1. WAIT_STATES=0. Write addr 0x10 = 0xDEADBEEF with pstrb=4'hF, then read 0x10 -> each transfer has pready=1 in its 2nd cycle; read returns prdata=0xDEADBEEF, pslverr=0.
2. Partial strobe: after test 1, write 0x10 = 0x11223344 with pstrb=4'b0101, then read -> 0xDE22BE44.
3. WAIT_STATES=3. Read 0x10 -> pready low for 3 access cycles, high on the 4th, with prdata valid only in that cycle.
4. DEPTH=64. Write 0x50 = 0xFFFFFFFF -> pslverr=1 with pready. A read of 0x50 returns prdata=0, pslverr=1. Word 0x10 (0x50 mod 64) is unchanged.
5. WAIT_STATES=2. Write 0x20 = 0xA5A5A5A5, drop psel during the first wait cycle -> no pready. A later read of 0x20 returns the old value.
6. WAIT_STATES=1. Pulse prst low during a write's access phase -> outputs 0 immediately and the write is not committed. A post-reset back-to-back write/read of 0x05 completes with no idle cycle between transfers.
